rv32_decode_queue: RTL and testbench
====================================

Name: rv32_decode_queue

Overview:
Buffered, handshaked RV32I decode stage between fetch and execute. Accepts {instr, pc} from fetch into a DEPTH-entry circular queue, decodes the head entry and holds the result in a registered output slot with valid/ready flow control. Flush empties the queue and the output slot, for redirects. Adds stricter illegal-encoding detection: funct7/funct3 checks, compressed encodings flagged invalid.

Parameters:
DEPTH, 4, queue entries; power of 2, >= 2
PTR_W, $clog2(DEPTH), derived; read/write pointer width
CNT_W, $clog2(DEPTH+1), derived; occupancy width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all queued and output-slot contents
in_valid  in  1  fetch offers an instruction
in_ready  out  1  queue can accept; registered, = (count != DEPTH)
in_instr  in  rv_instr_t  raw instruction word
in_pc  in  32  PC of in_instr
out_valid  out  1  output slot holds a decoded instruction
out_ready  in  1  execute consumes the slot this cycle
out_decoded  out  decoded_instr_t  decoded fields of slot
out_instr  out  rv_instr_t  raw word of slot
out_pc  out  32  PC of slot
occupancy  out  CNT_W  queue entries, output slot excluded

Behaviour:
- One clock domain (clk); rst synchronous, active-high. Reset: count=0, pointers=0, out_valid=0, in_ready=1, occupancy=0, out_decoded=NOP default (R-type, OP_NOP, ALU_OP_ADD, ALU_IN_ZERO x2, register_wb=0, WB_INT_ALU, invalid=0), out_instr=0, out_pc=0.
- push = in_valid & in_ready. pop_out = out_valid & out_ready. slot_free = ~out_valid | out_ready.
- Slot refill when slot_free: from queue head if count>0; else bypass from the current push if push=1; else out_valid<=0 next cycle.
- Bypass: empty queue and free slot -> pushed instruction is in the output slot next cycle (1-cycle latency). Otherwise it enters the queue at wptr.
- Simultaneous push and head-refill: count unchanged, both pointers advance, wrap modulo DEPTH.
- Full (count==DEPTH): in_ready=0 that cycle; in_valid ignored. in_ready never depends combinationally on out_ready.
- out_* stable while out_valid=1 and out_ready=0.
- flush: highest priority. Next cycle count=0, pointers=0, out_valid=0, in_ready=1. A push in the flush cycle is dropped. out_ready ignored in the flush cycle.
- rst with flush, or mid-transfer: rst wins; same state as flush.
- Decode is combinational on the selected source (head or bypass), registered into the slot. Per opcode:
  - LUI: U-type, i2=IMM, wb.
  - AUIPC: U-type, i1=PC, i2=IMM, wb.
  - JAL: J-type, OP_J, i1=PC, i2=IMM, wb.
  - JALR: OP_J, i1=REG_1, i2=IMM, wb; funct3!=0 -> invalid.
  - BRANCH: B-type, branch_op={0,funct3}, i1=PC, i2=IMM; funct3 010/011 -> invalid.
  - INTEGER_IMM: I-type, op={0,funct3}, except SRAI op={1,101}. Shifts: funct7 must be 0000000, or 0100000 for funct3=101; else invalid.
  - INTEGER_REG: op={funct7[5],funct3}. funct7 must be 0000000, or 0100000 with funct3 000/101; else invalid.
- Any other opcode, or opcode[1:0]!=11: invalid=1 with NOP default fields.
- Invalid instructions still flow through the slot; register_wb forced 0, branch_op=OP_NOP.

Optional Feature:
RV_DECODE_ILLEGAL_CNT_EN: adds port illegal_count out 16, a saturating count of slot loads with invalid=1, reset 0, unaffected by flush, holds at 0xFFFF. Without the macro, the port and counter are absent; decode behaviour is identical.

Test Plan:
- Reset, then in_valid with ADDI x1,x0,5 (0x00500093) at pc 0x100, out_ready=1 -> next cycle out_valid=1, out_pc=0x100, I-type, ADD, REG_1/IMM, register_wb=1, occupancy=0.
- out_ready=0, push 5 instructions (DEPTH=4) -> slot holds #1, occupancy=4, in_ready=0, #6 ignored; then out_ready=1 -> #2..#5 emerge in order, one per cycle, no loss.
- Continuous push+pop over 10 instructions with pointer wrap -> PCs sequential, out_valid held 1, occupancy constant.
- flush with 3 queued, slot full, push asserted -> next cycle out_valid=0, occupancy=0, in_ready=1; pushed word never appears.
- Illegal words 0x02000033 (MUL), 0x0000A067 (JALR funct3=2), 0x4000F0B3 (funct7=0100000, funct3=111), 0x00000001 (compressed) -> each invalid=1, register_wb=0; illegal_count=4 with RV_DECODE_ILLEGAL_CNT_EN.
- SRAI x1,x1,3 (0x4030D093) -> int_alu_op={1,101}, invalid=0; SUB (0x402080B3) -> op={1,000}, invalid=0.

Source files
------------

// File: rtl/rv32_decode_queue.sv
// RV32I decode stage: DEPTH-entry circular queue feeding a registered, valid/ready output slot.
// Optional macro RV_DECODE_ILLEGAL_CNT_EN adds a saturating illegal_count output.

package rv32_decode_pkg;

  typedef logic [31:0] rv_instr_t;

  localparam logic [2:0] INSTR_R = 3'd0;
  localparam logic [2:0] INSTR_I = 3'd1;
  localparam logic [2:0] INSTR_B = 3'd3;
  localparam logic [2:0] INSTR_U = 3'd4;
  localparam logic [2:0] INSTR_J = 3'd5;

  // branch_op: {1'b0, funct3} for conditional branches, plus jump and none.
  localparam logic [3:0] OP_J   = 4'b1000;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam logic [3:0] ALU_OP_ADD = 4'b0000;

  localparam logic [2:0] ALU_IN_ZERO  = 3'd0;
  localparam logic [2:0] ALU_IN_REG_1 = 3'd1;
  localparam logic [2:0] ALU_IN_REG_2 = 3'd2;
  localparam logic [2:0] ALU_IN_IMM   = 3'd3;
  localparam logic [2:0] ALU_IN_PC    = 3'd4;

  localparam logic [1:0] WB_INT_ALU = 2'd0;
  localparam logic [1:0] WB_PC_NEXT = 2'd1;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_INT_IMM = 7'b0010011;
  localparam logic [6:0] OPC_INT_REG = 7'b0110011;

  typedef struct packed {
    logic [2:0]  instr_type;
    logic [3:0]  branch_op;
    logic [3:0]  int_alu_op;
    logic [2:0]  alu_in_1;
    logic [2:0]  alu_in_2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        register_wb;
    logic [1:0]  wb_src;
    logic        invalid;
  } decoded_instr_t;

  function automatic decoded_instr_t nop_decoded();
    decoded_instr_t d;
    d             = '0;
    d.instr_type  = INSTR_R;
    d.branch_op   = OP_NOP;
    d.int_alu_op  = ALU_OP_ADD;
    d.alu_in_1    = ALU_IN_ZERO;
    d.alu_in_2    = ALU_IN_ZERO;
    d.register_wb = 1'b0;
    d.wb_src      = WB_INT_ALU;
    d.invalid     = 1'b0;
    return d;
  endfunction

  // Illegal encodings collapse to the NOP fields with invalid set, so they never write back or branch.
  function automatic decoded_instr_t decode(rv_instr_t instr);
    decoded_instr_t d;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_b, imm_u, imm_j;
    logic        ok;
    d      = nop_decoded();
    opcode = instr[6:0];
    f3     = instr[14:12];
    f7     = instr[31:25];
    imm_i  = {{20{instr[31]}}, instr[31:20]};
    imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u  = {instr[31:12], 12'b0};
    imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    ok     = 1'b1;
    if (opcode[1:0] != 2'b11) begin
      ok = 1'b0;
    end else begin
      case (opcode)
        OPC_LUI: begin
          d.instr_type = INSTR_U; d.alu_in_2 = ALU_IN_IMM; d.imm = imm_u;
          d.rd = instr[11:7]; d.register_wb = 1'b1;
        end
        OPC_AUIPC: begin
          d.instr_type = INSTR_U; d.alu_in_1 = ALU_IN_PC; d.alu_in_2 = ALU_IN_IMM;
          d.imm = imm_u; d.rd = instr[11:7]; d.register_wb = 1'b1;
        end
        OPC_JAL: begin
          d.instr_type = INSTR_J; d.branch_op = OP_J; d.alu_in_1 = ALU_IN_PC;
          d.alu_in_2 = ALU_IN_IMM; d.imm = imm_j; d.rd = instr[11:7];
          d.register_wb = 1'b1; d.wb_src = WB_PC_NEXT;
        end
        OPC_JALR: begin
          d.instr_type = INSTR_I; d.branch_op = OP_J; d.alu_in_1 = ALU_IN_REG_1;
          d.alu_in_2 = ALU_IN_IMM; d.imm = imm_i; d.rd = instr[11:7];
          d.rs1 = instr[19:15]; d.register_wb = 1'b1; d.wb_src = WB_PC_NEXT;
          ok = (f3 == 3'b000);
        end
        OPC_BRANCH: begin
          d.instr_type = INSTR_B; d.branch_op = {1'b0, f3}; d.alu_in_1 = ALU_IN_PC;
          d.alu_in_2 = ALU_IN_IMM; d.imm = imm_b; d.rs1 = instr[19:15]; d.rs2 = instr[24:20];
          ok = (f3 != 3'b010) && (f3 != 3'b011);
        end
        OPC_INT_IMM: begin
          d.instr_type = INSTR_I; d.int_alu_op = {1'b0, f3}; d.alu_in_1 = ALU_IN_REG_1;
          d.alu_in_2 = ALU_IN_IMM; d.imm = imm_i; d.rd = instr[11:7];
          d.rs1 = instr[19:15]; d.register_wb = 1'b1;
          // Only shifts carry funct7; SRAI is the single case that sets the ALU op MSB.
          if (f3 == 3'b001) begin
            ok = (f7 == 7'b0000000);
          end else if (f3 == 3'b101) begin
            ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            d.int_alu_op = {f7[5], f3};
          end
        end
        OPC_INT_REG: begin
          d.instr_type = INSTR_R; d.int_alu_op = {f7[5], f3}; d.alu_in_1 = ALU_IN_REG_1;
          d.alu_in_2 = ALU_IN_REG_2; d.rd = instr[11:7]; d.rs1 = instr[19:15];
          d.rs2 = instr[24:20]; d.register_wb = 1'b1;
          ok = (f7 == 7'b0000000) ||
               ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        end
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      d         = nop_decoded();
      d.invalid = 1'b1;
    end
    return d;
  endfunction

endpackage

// Handshakes: a transfer happens on a rising edge where valid && ready. Once valid is
// raised, the payload is held stable until the transfer; ready never depends on valid.
module rv32_decode_queue
  import rv32_decode_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  rv_instr_t        in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output decoded_instr_t   out_decoded,
  output rv_instr_t        out_instr,
  output logic [31:0]      out_pc,
  output logic [CNT_W-1:0] occupancy
`ifdef RV_DECODE_ILLEGAL_CNT_EN
  ,
  output logic [15:0]      illegal_count
`endif
);

  rv_instr_t        mem_instr [DEPTH];
  logic [31:0]      mem_pc    [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count, count_next;

  logic           push, slot_free, load_head, bypass, enq, slot_load;
  rv_instr_t      sel_instr;
  logic [31:0]    sel_pc;
  decoded_instr_t sel_dec;

  // Flush blocks every transfer in its cycle, including the push.
  assign push      = in_valid & in_ready & ~flush;
  assign slot_free = (~out_valid | out_ready) & ~flush;
  assign load_head = slot_free & (count != '0);
  assign bypass    = slot_free & (count == '0) & push;
  assign enq       = push & ~bypass;
  assign slot_load = load_head | bypass;
  assign occupancy = count;

  always_comb begin
    sel_instr = in_instr;
    sel_pc    = in_pc;
    if (load_head) begin
      sel_instr = mem_instr[rptr];
      sel_pc    = mem_pc[rptr];
    end
    sel_dec = decode(sel_instr);
  end

  always_comb begin
    count_next = count;
    case ({enq, load_head})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      mem_instr[wptr] <= in_instr;
      mem_pc[wptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_decoded <= nop_decoded();
      out_instr   <= '0;
      out_pc      <= '0;
    end else if (flush) begin
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      count    <= count_next;
      in_ready <= (count_next != CNT_W'(DEPTH));
      if (enq)       wptr <= wptr + PTR_W'(1);
      if (load_head) rptr <= rptr + PTR_W'(1);
      if (slot_load) begin
        out_valid   <= 1'b1;
        out_decoded <= sel_dec;
        out_instr   <= sel_instr;
        out_pc      <= sel_pc;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RV_DECODE_ILLEGAL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_count <= '0;
    end else if (slot_load && sel_dec.invalid && (illegal_count != 16'hFFFF)) begin
      illegal_count <= illegal_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_decode_queue.sv
// Directed bench for rv32_decode_queue: decode vector table plus queue/flush/reset sequences.
module tb_rv32_decode_queue;
  import rv32_decode_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  rv_instr_t      in_instr = '0;
  logic [31:0]    in_pc = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  decoded_instr_t out_decoded;
  rv_instr_t      out_instr;
  logic [31:0]    out_pc;
  logic [2:0]     occupancy;
`ifdef RV_DECODE_ILLEGAL_CNT_EN
  logic [15:0]    illegal_count;
`endif

  rv32_decode_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_decoded(out_decoded),
    .out_instr(out_instr), .out_pc(out_pc), .occupancy(occupancy)
`ifdef RV_DECODE_ILLEGAL_CNT_EN
    , .illegal_count(illegal_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  typ;
    logic [3:0]  alu;
    logic [3:0]  br;
    logic [2:0]  in1;
    logic [2:0]  in2;
    logic        wb;
    logic        inv;
    logic [31:0] imm;
  } vec_t;

  vec_t           vecs[$];
  logic [31:0]    exp_q[$];
  decoded_instr_t exp_nop;
  int             n_vec = 0;
  int             n_err = 0;
  int             n_illegal = 0;
  localparam logic [31:0] ADDI = 32'h00500093;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] ins, input logic [2:0] typ, input logic [3:0] alu,
                         input logic [3:0] br, input logic [2:0] in1, input logic [2:0] in2,
                         input logic wb, input logic inv, input logic [31:0] imm);
    vec_t v;
    v.instr = ins; v.typ = typ; v.alu = alu; v.br = br; v.in1 = in1; v.in2 = in2;
    v.wb = wb; v.inv = inv; v.imm = imm;
    vecs.push_back(v);
  endtask

  task automatic add_bad(input logic [31:0] ins);
    add_vec(ins, INSTR_R, 4'b0000, OP_NOP, ALU_IN_ZERO, ALU_IN_ZERO, 1'b0, 1'b1, 32'h0);
  endtask

  // One cycle, entered and left at a negedge; the scoreboard tracks accepted PCs in order.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                      input logic ordy, input logic fl);
    in_valid = iv; in_instr = ins; in_pc = p; out_ready = ordy; flush = fl;
    if (!fl) begin
      if (ordy && out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_unexpected_out: got pc %h expected nothing", out_pc);
        end else begin
          chk("out_pc_order", out_pc, exp_q.pop_front());
        end
      end
      if (iv && in_ready) exp_q.push_back(p);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, "_out_pc"}, out_pc, 32'h0);
    chk({tag, "_out_instr"}, out_instr, 32'h0);
    n_vec++;
    if (out_decoded !== exp_nop) begin
      n_err++;
      $display("FAIL %s_out_decoded: got %h expected %h", tag, out_decoded, exp_nop);
    end
  endtask

  initial begin
    exp_nop = '0;
    exp_nop.instr_type = 3'd0; exp_nop.branch_op = 4'b1111; exp_nop.int_alu_op = 4'b0000;
    exp_nop.alu_in_1 = 3'd0; exp_nop.alu_in_2 = 3'd0; exp_nop.register_wb = 1'b0;
    exp_nop.wb_src = 2'd0; exp_nop.invalid = 1'b0;

    add_vec(32'h4030D093, INSTR_I, 4'b1101, OP_NOP, ALU_IN_REG_1, ALU_IN_IMM, 1, 0, 32'h403);
    add_vec(32'h402080B3, INSTR_R, 4'b1000, OP_NOP, ALU_IN_REG_1, ALU_IN_REG_2, 1, 0, 32'h0);
    add_vec(32'h0020D0B3, INSTR_R, 4'b0101, OP_NOP, ALU_IN_REG_1, ALU_IN_REG_2, 1, 0, 32'h0);
    add_vec(32'h4020D0B3, INSTR_R, 4'b1101, OP_NOP, ALU_IN_REG_1, ALU_IN_REG_2, 1, 0, 32'h0);
    add_vec(32'h00309093, INSTR_I, 4'b0001, OP_NOP, ALU_IN_REG_1, ALU_IN_IMM, 1, 0, 32'h3);
    add_vec(32'h123450B7, INSTR_U, 4'b0000, OP_NOP, ALU_IN_ZERO, ALU_IN_IMM, 1, 0, 32'h12345000);
    add_vec(32'h00001097, INSTR_U, 4'b0000, OP_NOP, ALU_IN_PC, ALU_IN_IMM, 1, 0, 32'h1000);
    add_vec(32'h008000EF, INSTR_J, 4'b0000, OP_J, ALU_IN_PC, ALU_IN_IMM, 1, 0, 32'h8);
    add_vec(32'h000080E7, INSTR_I, 4'b0000, OP_J, ALU_IN_REG_1, ALU_IN_IMM, 1, 0, 32'h0);
    add_vec(32'h00208463, INSTR_B, 4'b0000, 4'b0000, ALU_IN_PC, ALU_IN_IMM, 0, 0, 32'h8);
    add_vec(32'h0020C463, INSTR_B, 4'b0000, 4'b0100, ALU_IN_PC, ALU_IN_IMM, 0, 0, 32'h8);
    add_bad(32'h02000033);
    add_bad(32'h0000A067);
    add_bad(32'h4000F0B3);
    add_bad(32'h00000001);
    add_bad(32'h0020A463);
    add_bad(32'h40309093);
    add_bad(32'h00002083);

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");
`ifdef RV_DECODE_ILLEGAL_CNT_EN
    chk("reset_illegal_count", 32'(illegal_count), 32'd0);
`endif

    // First instruction bypasses straight into the slot
    step(1, ADDI, 32'h100, 1, 0);
    chk("addi_out_valid", 32'(out_valid), 32'd1);
    chk("addi_out_pc", out_pc, 32'h100);
    chk("addi_occupancy", 32'(occupancy), 32'd0);
    chk("addi_type", 32'(out_decoded.instr_type), 32'(INSTR_I));
    chk("addi_alu", 32'(out_decoded.int_alu_op), 32'(ALU_OP_ADD));
    chk("addi_in1", 32'(out_decoded.alu_in_1), 32'(ALU_IN_REG_1));
    chk("addi_in2", 32'(out_decoded.alu_in_2), 32'(ALU_IN_IMM));
    chk("addi_wb", 32'(out_decoded.register_wb), 32'd1);
    chk("addi_imm", out_decoded.imm, 32'd5);

    // Decode table, one bypassed instruction per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      step(1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1, 0);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_instr", i), out_instr, vecs[i].instr);
      chk($sformatf("v%0d_type", i), 32'(out_decoded.instr_type), 32'(vecs[i].typ));
      chk($sformatf("v%0d_alu", i), 32'(out_decoded.int_alu_op), 32'(vecs[i].alu));
      chk($sformatf("v%0d_br", i), 32'(out_decoded.branch_op), 32'(vecs[i].br));
      chk($sformatf("v%0d_in1", i), 32'(out_decoded.alu_in_1), 32'(vecs[i].in1));
      chk($sformatf("v%0d_in2", i), 32'(out_decoded.alu_in_2), 32'(vecs[i].in2));
      chk($sformatf("v%0d_wb", i), 32'(out_decoded.register_wb), 32'(vecs[i].wb));
      chk($sformatf("v%0d_invalid", i), 32'(out_decoded.invalid), 32'(vecs[i].inv));
      chk($sformatf("v%0d_imm", i), out_decoded.imm, vecs[i].imm);
      if (vecs[i].inv) n_illegal++;
    end
    step(0, 32'h0, 32'h0, 1, 0);
    chk("table_drained", 32'(out_valid), 32'd0);
`ifdef RV_DECODE_ILLEGAL_CNT_EN
    chk("illegal_count", 32'(illegal_count), 32'(n_illegal));
`endif

    // Fill to full with the slot stalled; the sixth word must be refused
    for (int k = 0; k < 6; k++) begin
      step(1, ADDI, 32'h200 + 32'(k * 4), 0, 0);
      chk("stall_out_pc_stable", out_pc, 32'h200);
    end
    chk("full_occupancy", 32'(occupancy), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    chk("drain_occupancy", 32'(occupancy), 32'd3);
    for (int k = 0; k < 4; k++) step(0, 32'h0, 32'h0, 1, 0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    // Steady push+pop with two entries queued, wrapping the pointers
    for (int k = 0; k < 3; k++) step(1, ADDI, 32'h300 + 32'(k * 4), 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(1, ADDI, 32'h30C + 32'(k * 4), 1, 0);
      chk("stream_out_valid", 32'(out_valid), 32'd1);
      chk("stream_occupancy", 32'(occupancy), 32'd2);
    end
    for (int k = 0; k < 3; k++) step(0, 32'h0, 32'h0, 1, 0);
    chk("stream_out_valid_end", 32'(out_valid), 32'd0);
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush with slot full, three queued and a push in the same cycle
    for (int k = 0; k < 4; k++) step(1, ADDI, 32'h400 + 32'(k * 4), 0, 0);
    chk("preflush_occupancy", 32'(occupancy), 32'd3);
    step(1, ADDI, 32'hDEAD0, 1, 1);
    exp_q.delete();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_occupancy", 32'(occupancy), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 2; k++) begin
      step(0, 32'h0, 32'h0, 1, 0);
      chk("postflush_out_valid", 32'(out_valid), 32'd0);
    end
    step(1, ADDI, 32'h500, 1, 0);
    chk("postflush_pc", out_pc, 32'h500);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("postflush_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset together with flush in the middle of traffic
    for (int k = 0; k < 2; k++) step(1, ADDI, 32'h600 + 32'(k * 4), 0, 0);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h700; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk_reset_state("rst_mid");
`ifdef RV_DECODE_ILLEGAL_CNT_EN
    chk("rst_mid_illegal_count", 32'(illegal_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
